// File: rtl/ula_sequenciador_entrada.sv
// rtl/ula_sequenciador_entrada.sv - operand-entry sequencer for the 6-bit ULA; optional debouncer under ULA_SEQ_DEBOUNCE_EN
module ula_sequenciador_entrada #(
   parameter int WIDTH           = 6,
   parameter int LAT_ULA         = 3,
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dado_in,
   input  logic [2:0]       op_in,
   input  logic             modo_in,
   input  logic             botao,
   input  logic             cancelar,
   output logic [WIDTH-1:0] ula_a,
   output logic [WIDTH-1:0] ula_b,
   output logic [2:0]       ula_operacao,
   output logic             ula_modo,
   output logic             ula_rst,
   input  logic [WIDTH-1:0] ula_resultado,
   input  logic             ula_overflow,
   input  logic             ula_zero,
   output logic [WIDTH-1:0] resultado,
   output logic             overflow,
   output logic             zero,
   output logic             pronto,
   output logic [2:0]       estado
);

   localparam int CW = $clog2(LAT_ULA + 1);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } estado_t;

   // Elaboration-time sanity check of the parameter set
   if (LAT_ULA < 1 || DEBOUNCE_CICLOS < 2) begin : g_param_invalido
      $error("ula_sequenciador_entrada: LAT_ULA must be >=1 and DEBOUNCE_CICLOS >=2");
   end

   estado_t          est_q, est_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [WIDTH-1:0] a_d, b_d, res_d;
   logic [2:0]       op_d;
   logic             modo_d, ov_d, z_d, pronto_d;

   logic botao_s1, botao_s2;
   logic nivel, nivel_ant;
   logic press;

   // Two-flop synchronizer for the asynchronous push-button
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         botao_s1 <= 1'b0;
         botao_s2 <= 1'b0;
      end else begin
         botao_s1 <= botao;
         botao_s2 <= botao_s1;
      end
   end

`ifdef ULA_SEQ_DEBOUNCE_EN
   localparam int DB_CW = $clog2(DEBOUNCE_CICLOS + 1);

   logic [DB_CW-1:0] db_cnt;
   logic             db_nivel;

   // Filtered level follows the synchronized button only after a full run of equal samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt   <= '0;
         db_nivel <= 1'b0;
      end else if (botao_s2 != db_nivel) begin
         if (db_cnt == DB_CW'(DEBOUNCE_CICLOS - 1)) begin
            db_nivel <= botao_s2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + DB_CW'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   assign nivel = db_nivel;
`else
   assign nivel = botao_s2;
`endif

   // Previous level for rising-edge detection; a held button yields a single press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nivel_ant <= 1'b0;
      end else begin
         nivel_ant <= nivel;
      end
   end

   assign press = nivel & ~nivel_ant;

   // State, operand, latency counter and captured-result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         est_q        <= S_A;
         cnt          <= '0;
         ula_a        <= '0;
         ula_b        <= '0;
         ula_operacao <= '0;
         ula_modo     <= 1'b0;
         resultado    <= '0;
         overflow     <= 1'b0;
         zero         <= 1'b0;
         pronto       <= 1'b0;
      end else begin
         est_q        <= est_d;
         cnt          <= cnt_d;
         ula_a        <= a_d;
         ula_b        <= b_d;
         ula_operacao <= op_d;
         ula_modo     <= modo_d;
         resultado    <= res_d;
         overflow     <= ov_d;
         zero         <= z_d;
         pronto       <= pronto_d;
      end
   end

   // ULA reset pulse: high out of reset and for one cycle after an abort
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ula_rst <= 1'b1;
      end else begin
         ula_rst <= cancelar;
      end
   end

   // Next-state and next-value logic; abort overrides any same-cycle press
   always_comb begin
      est_d    = est_q;
      cnt_d    = cnt;
      a_d      = ula_a;
      b_d      = ula_b;
      op_d     = ula_operacao;
      modo_d   = ula_modo;
      res_d    = resultado;
      ov_d     = overflow;
      z_d      = zero;
      pronto_d = pronto;

      if (cancelar) begin
         est_d    = S_A;
         pronto_d = 1'b0;
         res_d    = '0;
         ov_d     = 1'b0;
         z_d      = 1'b0;
      end else begin
         case (est_q)
            S_A: begin
               if (press) begin
                  a_d   = dado_in;
                  est_d = S_B;
               end
            end
            S_B: begin
               if (press) begin
                  b_d   = dado_in;
                  est_d = S_OP;
               end
            end
            S_OP: begin
               if (press) begin
                  op_d   = op_in;
                  modo_d = modo_in;
                  cnt_d  = CW'(LAT_ULA);
                  est_d  = S_EXEC;
               end
            end
            S_EXEC: begin
               // ULA inputs stay frozen here; presses are deliberately dropped
               cnt_d = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  res_d    = ula_resultado;
                  ov_d     = ula_overflow;
                  z_d      = ula_zero;
                  pronto_d = 1'b1;
                  est_d    = S_SHOW;
               end
            end
            S_SHOW: begin
               if (press) begin
                  pronto_d = 1'b0;
                  est_d    = S_A;
               end
            end
            default: begin
               est_d = S_A;
            end
         endcase
      end
   end

   assign estado = est_q;

endmodule

// File: tb/tb_ula_sequenciador_entrada.sv
// tb/tb_ula_sequenciador_entrada.sv - directed self-checking bench for ula_sequenciador_entrada
module tb_ula_sequenciador_entrada;

   localparam int W   = 6;
   localparam int LAT = 3;
   localparam int DEB = 16;
`ifdef ULA_SEQ_DEBOUNCE_EN
   localparam int NDB = DEB;
`else
   localparam int NDB = 0;
`endif
   localparam int HOLD = 4 + NDB;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] dado_in;
   logic [2:0]   op_in;
   logic         modo_in;
   logic         botao;
   logic         cancelar;
   logic [W-1:0] ula_a, ula_b;
   logic [2:0]   ula_operacao;
   logic         ula_modo, ula_rst;
   logic [W-1:0] ula_resultado;
   logic         ula_overflow, ula_zero;
   logic [W-1:0] resultado;
   logic         overflow, zero, pronto;
   logic [2:0]   estado;

   int testes = 0;
   int falhas = 0;

   always #5 clk = ~clk;

   ula_sequenciador_entrada #(
      .WIDTH(W), .LAT_ULA(LAT), .DEBOUNCE_CICLOS(DEB)
   ) dut (
      .clk(clk), .reset(reset), .dado_in(dado_in), .op_in(op_in), .modo_in(modo_in),
      .botao(botao), .cancelar(cancelar), .ula_a(ula_a), .ula_b(ula_b),
      .ula_operacao(ula_operacao), .ula_modo(ula_modo), .ula_rst(ula_rst),
      .ula_resultado(ula_resultado), .ula_overflow(ula_overflow), .ula_zero(ula_zero),
      .resultado(resultado), .overflow(overflow), .zero(zero), .pronto(pronto),
      .estado(estado)
   );

   // Two-stage registered ULA stand-in: add (modo 0, op 000) and OR (modo 1, op 100)
   logic [W:0] p1, p2;
   always @(posedge clk) begin
      if (!ula_modo && ula_operacao == 3'b000)
         p1 <= {1'b0, ula_a} + {1'b0, ula_b};
      else if (ula_modo && ula_operacao == 3'b100)
         p1 <= {1'b0, ula_a | ula_b};
      else
         p1 <= '0;
      p2 <= p1;
   end
   assign ula_resultado = p2[W-1:0];
   assign ula_overflow  = p2[W];
   assign ula_zero      = (p2[W-1:0] == '0);

   task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
      testes++;
      if (obtido !== esperado) begin
         falhas++;
         $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obtido, esperado);
      end
   endtask

   task automatic aperta(input int hold);
      @(negedge clk) botao = 1'b1;
      repeat (hold) @(negedge clk);
      botao = 1'b0;
      repeat (4 + NDB) @(negedge clk);
   endtask

   task automatic espera_estado(input logic [2:0] alvo, input int limite, input string tag);
      int n = 0;
      while (estado !== alvo && n < limite) begin
         @(negedge clk);
         n++;
      end
      verifica(tag, estado, alvo);
   endtask

   task automatic carrega(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic modo);
      dado_in = a;
      aperta(HOLD);
      verifica("estado_apos_a", estado, 3'd1);
      dado_in = b;
      aperta(HOLD);
      verifica("estado_apos_b", estado, 3'd2);
      op_in   = op;
      modo_in = modo;
   endtask

   // Raises the button for the op step and checks capture lands exactly LAT cycles later
   task automatic op_com_latencia();
      @(negedge clk) botao = 1'b1;
      espera_estado(3'd3, 10 + NDB, "entra_exec");
      for (int i = 1; i < LAT; i++) begin
         @(negedge clk);
         verifica("pronto_cedo", pronto, 1'b0);
      end
      @(negedge clk);
      verifica("estado_show", estado, 3'd4);
      verifica("pronto_show", pronto, 1'b1);
      botao = 1'b0;
      repeat (4 + NDB) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: obtido=timeout esperado=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; dado_in = '0; op_in = '0; modo_in = 1'b0; botao = 1'b0; cancelar = 1'b0;
      repeat (3) @(negedge clk);
      verifica("rst_estado", estado, 3'd0);
      verifica("rst_ula_rst", ula_rst, 1'b1);
      verifica("rst_pronto", pronto, 1'b0);
      verifica("rst_ula_a", ula_a, 6'd0);
      verifica("rst_resultado", resultado, 6'd0);
      reset = 1'b1;
      #1 verifica("ula_rst_1o_ciclo", ula_rst, 1'b1);
      @(negedge clk);
      verifica("ula_rst_baixa", ula_rst, 1'b0);

      // 1: 5 + 3
      carrega(6'd5, 6'd3, 3'b000, 1'b0);
      verifica("t1_ula_a", ula_a, 6'd5);
      verifica("t1_ula_b", ula_b, 6'd3);
      op_com_latencia();
      verifica("t1_resultado", resultado, 6'd8);
      verifica("t1_overflow", overflow, 1'b0);
      verifica("t1_zero", zero, 1'b0);
      aperta(HOLD);
      verifica("t1_volta_a", estado, 3'd0);
      verifica("t1_pronto_0", pronto, 1'b0);
      verifica("t1_res_retido", resultado, 6'd8);

      // 2: 63 + 1 wraps with overflow
      carrega(6'd63, 6'd1, 3'b000, 1'b0);
      op_com_latencia();
      verifica("t2_resultado", resultado, 6'd0);
      verifica("t2_overflow", overflow, 1'b1);
      verifica("t2_zero", zero, 1'b1);
      aperta(HOLD);

      // 3: logic OR, button held 50 cycles gives one press
      carrega(6'h2A, 6'h15, 3'b100, 1'b1);
      @(negedge clk) botao = 1'b1;
      espera_estado(3'd3, 10 + NDB, "t3_exec");
      repeat (50) @(negedge clk);
      verifica("t3_estado", estado, 3'd4);
      verifica("t3_pronto", pronto, 1'b1);
      verifica("t3_resultado", resultado, 6'h3F);
      verifica("t3_overflow", overflow, 1'b0);
      verifica("t3_ula_op", ula_operacao, 3'b100);
      verifica("t3_ula_modo", ula_modo, 1'b1);
      botao = 1'b0;
      repeat (4 + NDB) @(negedge clk);
      aperta(HOLD);

      // 4: cancel in S_B coinciding with a press
      dado_in = 6'd7;
      aperta(HOLD);
      verifica("t4_em_b", estado, 3'd1);
      dado_in = 6'd9;
      @(negedge clk) botao = 1'b1;
      repeat (2 + NDB) @(negedge clk);
      cancelar = 1'b1;
      @(negedge clk) cancelar = 1'b0;
      verifica("t4_estado", estado, 3'd0);
      verifica("t4_pronto", pronto, 1'b0);
      verifica("t4_resultado", resultado, 6'd0);
      verifica("t4_ula_rst", ula_rst, 1'b1);
      verifica("t4_ula_a", ula_a, 6'd7);
      verifica("t4_ula_b", ula_b, 6'h15);
      @(negedge clk);
      verifica("t4_ula_rst_fim", ula_rst, 1'b0);
      verifica("t4_estado_fim", estado, 3'd0);
      botao = 1'b0;
      repeat (4 + NDB) @(negedge clk);

`ifndef ULA_SEQ_DEBOUNCE_EN
      // 5a: second tap lands inside S_EXEC and must be ignored
      carrega(6'd1, 6'd2, 3'b000, 1'b0);
      @(negedge clk) botao = 1'b1;
      @(negedge clk) botao = 1'b0;
      @(negedge clk) botao = 1'b1;
      @(negedge clk) botao = 1'b0;
      espera_estado(3'd4, 10, "t5_show");
      repeat (4) @(negedge clk);
      verifica("t5_fica_show", estado, 3'd4);
      verifica("t5_resultado", resultado, 6'd3);
      aperta(HOLD);
`endif

      // 5b: reset mid-S_EXEC
      carrega(6'd10, 6'd20, 3'b000, 1'b0);
      @(negedge clk) botao = 1'b1;
      espera_estado(3'd3, 10 + NDB, "t5_exec");
      reset = 1'b0;
      #1;
      verifica("t5_rst_estado", estado, 3'd0);
      verifica("t5_rst_ula_rst", ula_rst, 1'b1);
      verifica("t5_rst_ula_a", ula_a, 6'd0);
      verifica("t5_rst_ula_b", ula_b, 6'd0);
      botao = 1'b0;
      repeat (6) @(negedge clk);
      verifica("t5_rst_pronto", pronto, 1'b0);
      verifica("t5_rst_resultado", resultado, 6'd0);
      reset = 1'b1;
      @(negedge clk);
      verifica("t5_pos_ula_rst", ula_rst, 1'b0);
      verifica("t5_pos_estado", estado, 3'd0);

`ifdef ULA_SEQ_DEBOUNCE_EN
      // 6: short glitch filtered, long hold accepted once
      dado_in = 6'h11;
      @(negedge clk) botao = 1'b1;
      repeat (5) @(negedge clk);
      botao = 1'b0;
      repeat (30) @(negedge clk);
      verifica("t6_glitch", estado, 3'd0);
      botao = 1'b1;
      repeat (20) @(negedge clk);
      botao = 1'b0;
      repeat (DEB + 6) @(negedge clk);
      verifica("t6_press", estado, 3'd1);
      verifica("t6_ula_a", ula_a, 6'h11);
`endif

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
